// File: rtl/chain_seq_pkg.sv
// Shared types and constants for the inverting-chain token sequencer.
package chain_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ORDER   = 2'd2;
  localparam logic [1:0] ERR_GLITCH  = 2'd3;

  // Settled level of stage k for a given chain input: even stages invert.
  function automatic logic stage_expect(input logic drive_lvl, input int unsigned k);
    return drive_lvl ^ ~k[0];
  endfunction

endpackage

// File: rtl/tap_sync.sv
// Two-flop synchronizer bank for chain taps arriving from the prsim side.
module tap_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Plain double-register; reset clears both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/chain_sequencer.sv
// Launches n_tokens transitions into an inverting chain, one at a time, and
// watches each ripple through every stage in order.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   LAUNCH | toggle drive, reset stage pointer and wait/latency counters
//   WAIT   | track arrivals stage by stage; detect glitch/order/timeout
//   NEXT   | book-keep the finished token; decide DONE or next LAUNCH
//   DONE   | run finished cleanly; done held high
//   ERR    | run aborted; err/err_code/err_stage held
module chain_sequencer #(
  parameter int STAGES  = 5,
  parameter int TIMEOUT = 15,
  parameter int COUNT_W = 8,
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] n_tokens,
  input  logic [STAGES-1:0]  taps,
  output logic               drive,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [SW-1:0]      err_stage,
  output logic [COUNT_W-1:0] tokens_done,
  output logic [COUNT_W-1:0] lat_max
);

  import chain_seq_pkg::*;

  localparam int PW = $clog2(STAGES + 1);
  localparam logic [COUNT_W-1:0] TO_VAL = COUNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic               drive_q, drive_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [COUNT_W-1:0] wcnt_q, wcnt_d;
  logic [COUNT_W-1:0] lcnt_q, lcnt_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic [COUNT_W-1:0] tokens_q, tokens_d;
  logic [COUNT_W-1:0] lat_max_q, lat_max_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [SW-1:0]      err_stage_q, err_stage_d;

  logic [STAGES-1:0]  s_taps;
  logic [STAGES-1:0]  match;
  logic               run;
  int                 ptr_int;
  int                 m_cnt;
  int                 ptr_new;
  logic               order_hit, glitch_hit, pre_hit;
  logic [SW-1:0]      order_idx, glitch_idx, pre_idx;

  tap_sync #(.W(STAGES)) u_tap_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (taps),
    .q_o   (s_taps)
  );

  // Classify every synchronized tap against the level the current drive implies.
  always_comb begin
    match      = '0;
    run        = 1'b1;
    ptr_int    = int'(ptr_q);
    m_cnt      = 0;
    order_hit  = 1'b0;
    order_idx  = '0;
    glitch_hit = 1'b0;
    glitch_idx = '0;
    pre_hit    = 1'b0;
    pre_idx    = '0;
    for (int k = 0; k < STAGES; k++) begin
      match[k] = (s_taps[k] == stage_expect(drive_q, k));
    end
    // Several stages can land in one cycle; advance over the contiguous run.
    for (int k = 0; k < STAGES; k++) begin
      if (k >= ptr_int) begin
        if (run && match[k]) m_cnt = m_cnt + 1;
        else                 run   = 1'b0;
      end
    end
    ptr_new = ptr_int + m_cnt;
    // Scan downwards so the lowest offending index is the one kept.
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k > ptr_new && match[k]) begin
        order_hit = 1'b1;
        order_idx = SW'(k);
      end
      if (k < ptr_int && !match[k]) begin
        glitch_hit = 1'b1;
        glitch_idx = SW'(k);
      end
      if (!match[k]) begin
        pre_hit = 1'b1;
        pre_idx = SW'(k);
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    drive_d     = drive_q;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    lcnt_d      = lcnt_q;
    n_d         = n_q;
    tokens_d    = tokens_q;
    lat_max_d   = lat_max_q;
    err_code_d  = err_code_q;
    err_stage_d = err_stage_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          n_d         = n_tokens;
          tokens_d    = '0;
          lat_max_d   = '0;
          err_code_d  = ERR_NONE;
          err_stage_d = '0;
          if (pre_hit) begin
            state_d     = ERR;
            err_code_d  = ERR_GLITCH;
            err_stage_d = pre_idx;
          end else if (n_tokens == '0) begin
            state_d = DONE;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        drive_d = ~drive_q;
        ptr_d   = '0;
        wcnt_d  = '0;
        lcnt_d  = COUNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        ptr_d = PW'(ptr_new);
        if (m_cnt == 0) wcnt_d = wcnt_q + 1'b1;
        else            wcnt_d = '0;
        if (glitch_hit) begin
          state_d     = ERR;
          err_code_d  = ERR_GLITCH;
          err_stage_d = glitch_idx;
        end else if (order_hit) begin
          state_d     = ERR;
          err_code_d  = ERR_ORDER;
          err_stage_d = order_idx;
        end else if (m_cnt == 0 && (wcnt_q + 1'b1) == TO_VAL) begin
          state_d     = ERR;
          err_code_d  = ERR_TIMEOUT;
          err_stage_d = SW'(ptr_q);
        end else if (ptr_new == STAGES) begin
          // The cycle that sees the last tap closes the measurement, so an
          // instantaneous chain reports launch + two sync flops = 3.
          state_d = NEXT;
        end else if (lcnt_q != '1) begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      NEXT: begin
        tokens_d = tokens_q + 1'b1;
        if (lcnt_q > lat_max_q) lat_max_d = lcnt_q;
        if ((tokens_q + 1'b1) == n_q) state_d = DONE;
        else                          state_d = LAUNCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drive_q     <= 1'b0;
      ptr_q       <= '0;
      wcnt_q      <= '0;
      lcnt_q      <= '0;
      n_q         <= '0;
      tokens_q    <= '0;
      lat_max_q   <= '0;
      err_code_q  <= ERR_NONE;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      drive_q     <= drive_d;
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      lcnt_q      <= lcnt_d;
      n_q         <= n_d;
      tokens_q    <= tokens_d;
      lat_max_q   <= lat_max_d;
      err_code_q  <= err_code_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign drive       = drive_q;
  assign busy        = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == NEXT);
  assign done        = (state_q == DONE);
  assign err         = (state_q == ERR);
  assign err_code    = err_code_q;
  assign err_stage   = err_stage_q;
  assign tokens_done = tokens_q;
  assign lat_max     = lat_max_q;

endmodule

// File: tb/tb_chain_sequencer.sv
// Bench: behavioural chain model with random per-stage delays; expected
// results derived from arrival times rather than from the controller logic.
module tb_chain_sequencer;

  localparam int STAGES  = 5;
  localparam int TIMEOUT = 15;
  localparam int COUNT_W = 8;
  localparam int SW      = $clog2(STAGES);
  // Pin change -> two sync flops -> seen on the following evaluation edge.
  localparam int SEEN    = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [COUNT_W-1:0] n_tokens;
  logic [STAGES-1:0]  taps;
  logic               drive, busy, done, err;
  logic [1:0]         err_code;
  logic [SW-1:0]      err_stage;
  logic [COUNT_W-1:0] tokens_done, lat_max;

  int vectors     = 0;
  int miscompares = 0;
  bit drv_model   = 1'b0;
  int dly [STAGES];

  chain_sequencer #(.STAGES(STAGES), .TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_tokens    (n_tokens),
    .taps        (taps),
    .drive       (drive),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .err_stage   (err_stage),
    .tokens_done (tokens_done),
    .lat_max     (lat_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Settled chain for a given input level: stage 0 inverts, stage 1 follows, ...
  function automatic logic [STAGES-1:0] settled(input bit d);
    logic [STAGES-1:0] v;
    for (int k = 0; k < STAGES; k++) v[k] = (k % 2 == 0) ? ~d : d;
    return v;
  endfunction

  task automatic settle_taps();
    taps = settled(drv_model);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start(input int n);
    start    = 1'b1;
    n_tokens = COUNT_W'(n);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_launch(input string tag);
    int g = 0;
    while (drive === drv_model && g < 40) begin
      @(negedge clk);
      g++;
    end
    drv_model = ~drv_model;
    chk(tag, drive, drv_model);
  endtask

  // Ripple stages [0, upto) with the delays in dly; returns launch-to-last delay.
  task automatic ripple(input int upto, output int total);
    total = 0;
    for (int k = 0; k < upto; k++) begin
      repeat (dly[k]) @(negedge clk);
      total += dly[k];
      taps[k] = ~taps[k];
    end
  endtask

  task automatic wait_end(output int g);
    g = 0;
    while (!done && !err && g < 120) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic ideal_delays();
    dly[0] = 0;
    for (int k = 1; k < STAGES; k++) dly[k] = 1;
  endtask

  task automatic clean_run(input string tag, input int n, input bit rnd);
    int tot, worst, g;
    worst = 0;
    pulse_start(n);
    for (int t = 0; t < n; t++) begin
      if (rnd) for (int k = 0; k < STAGES; k++) dly[k] = $urandom_range(0, 3);
      else     ideal_delays();
      wait_launch({tag, "_launch"});
      ripple(STAGES, tot);
      if (tot + SEEN > worst) worst = tot + SEEN;
      if (t == 0) begin
        chk({tag, "_busy"}, busy, 1);
        pulse_start($urandom_range(1, 255));
      end
    end
    wait_end(g);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_tokens"}, tokens_done, n);
    chk({tag, "_lat_max"}, lat_max, worst);
    chk({tag, "_drive"}, drive, drv_model);
  endtask

  task automatic check_err(input string tag, input int code, input int stage);
    int g;
    wait_end(g);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_code"}, err_code, code);
    chk({tag, "_stage"}, err_stage, stage);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int tot, g;
    reset    = 1'b1;
    start    = 1'b0;
    n_tokens = '0;
    taps     = settled(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_drive", drive, 0);
    chk("rst_flags", {busy, done, err}, 0);
    chk("rst_code", err_code, 0);
    chk("rst_counts", {tokens_done, lat_max}, 0);
    reset = 1'b0;

    // Pre-check: all taps low while drive=0 -> stage 0 mismatches.
    taps = '0;
    repeat (3) @(negedge clk);
    pulse_start(3);
    chk("pre_err", err, 1);
    chk("pre_code", err_code, 3);
    chk("pre_stage", err_stage, 0);
    chk("pre_busy", busy, 0);
    chk("pre_drive", drive, 0);
    settle_taps();

    // Zero tokens: DONE right after start, drive untouched, err cleared.
    pulse_start(0);
    chk("zero_done", done, 1);
    chk("zero_err", err, 0);
    chk("zero_busy", busy, 0);
    chk("zero_drive", drive, 0);
    chk("zero_tokens", tokens_done, 0);

    // Ideal chain, one cycle per stage, four tokens.
    clean_run("ideal", 4, 1'b0);
    chk("ideal_latency", lat_max, STAGES + 2);
    chk("ideal_drive0", drive, 0);

    // Stage 2 stuck: timeout TIMEOUT cycles after stage 1 is seen.
    pulse_start(2);
    wait_launch("stuck_launch");
    ideal_delays();
    ripple(2, tot);
    g = 0;
    while (!err && g < 80) begin
      @(negedge clk);
      g++;
    end
    chk("stuck_delay", g, TIMEOUT + SEEN);
    check_err("stuck", 1, 2);
    settle_taps();

    // Stage 3 overtakes stage 2.
    pulse_start(1);
    wait_launch("order_launch");
    ideal_delays();
    ripple(2, tot);
    @(negedge clk);
    taps[3] = ~taps[3];
    check_err("order", 2, 3);
    settle_taps();

    // Stage 1 drops back for one cycle after it has been counted.
    pulse_start(1);
    wait_launch("glitch_launch");
    ideal_delays();
    ripple(2, tot);
    repeat (3) @(negedge clk);
    taps[1] = ~taps[1];
    @(negedge clk);
    taps[1] = ~taps[1];
    check_err("glitch", 3, 1);
    settle_taps();

    // Glitch and order in the same cycle: glitch is reported.
    pulse_start(1);
    wait_launch("prio_launch");
    ideal_delays();
    ripple(2, tot);
    repeat (3) @(negedge clk);
    taps[1] = ~taps[1];
    taps[3] = ~taps[3];
    check_err("prio", 3, 1);
    settle_taps();

    // Randomized clean runs.
    for (int r = 0; r < 10; r++) begin
      clean_run($sformatf("rnd%0d", r), $urandom_range(1, 6), 1'b1);
    end

    // Reset in the middle of token 2.
    pulse_start(4);
    ideal_delays();
    wait_launch("mid_launch1");
    ripple(STAGES, tot);
    wait_launch("mid_launch2");
    chk("mid_tokens", tokens_done, 1);
    taps[0] = ~taps[0];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_drive", drive, 0);
    chk("mid_rst_flags", {busy, done, err}, 0);
    chk("mid_rst_err", {err_code, err_stage}, 0);
    chk("mid_rst_counts", {tokens_done, lat_max}, 0);
    drv_model = 1'b0;
    settle_taps();
    clean_run("post_rst", 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
